cam_capture_packer: RTL and testbench

//  Parametrised successor to the 4-bit OV7670 pixel capture stage. Samples the camera
//  bus on pclk, packs BYTES_PER_PIX bus beats into one pixel word, and applies H/V

---
 rtl/cam_capture_packer_if.sv | 27 ++
 rtl/cam_capture_packer.sv | 172 +++++++++++++++++
 tb/tb_cam_capture_packer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_packer_if.sv
// Camera-side and frame-buffer-side signal bundle for cam_capture_packer.
// The camera drives pixd/vsync/href; the packer drives the BRAM write port.
`timescale 1ns/1ps
interface cam_capture_packer_if #(
  parameter int DATA_W        = 4,
  parameter int BYTES_PER_PIX = 2,
  parameter int ADDR_W        = 10
);
  logic [DATA_W-1:0]               pixd;
  logic                            vsync;
  logic                            href;
  logic [DATA_W*BYTES_PER_PIX-1:0] WDATA;
  logic [ADDR_W-1:0]               WADDR;
  logic                            WE;

  // camera / stimulus side
  modport master (
    output pixd, vsync, href,
    input  WDATA, WADDR, WE
  );

  // packer side
  modport slave (
    input  pixd, vsync, href,
    output WDATA, WADDR, WE
  );
endinterface

// File: rtl/cam_capture_packer.sv
// Camera capture packer: registers the camera bus, packs BYTES_PER_PIX beats per
// pixel (first beat in the MS bits), applies H/V decimation and writes pixels
// linearly into a 2**ADDR_W word frame buffer, one armed/continuous frame at a time.
`timescale 1ns/1ps
module cam_capture_packer #(
  parameter int DATA_W        = 4,
  parameter int BYTES_PER_PIX = 2,
  parameter int ADDR_W        = 10,
  parameter int H_DECIM       = 1,
  parameter int V_DECIM       = 1
) (
  input  logic                     pclk,
  input  logic                     rst,
  cam_capture_packer_if.slave      cam,
  input  logic                     arm,
  input  logic                     continuous,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overflow,
  output logic [9:0]               line_cnt
);

  localparam int PIX_W = DATA_W * BYTES_PER_PIX;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_VS = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_FULL    = 2'd3;

  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [0:0]      PH_LAST   = 1'(BYTES_PER_PIX - 1);
  localparam logic [2:0]      H_LAST    = 3'(H_DECIM - 1);
  localparam logic [2:0]      V_LAST    = 3'(V_DECIM - 1);

  logic [1:0]        state;

  // stage-1 copies of the camera pins plus one more sample for edge detection
  logic [DATA_W-1:0] pixd_r;
  logic              vsync_r, vsync_q;
  logic              href_r, href_q;

  logic [0:0]        phase;
  logic [DATA_W-1:0] hist;
  logic [2:0]        col_mod;
  logic [2:0]        line_mod;
  logic [ADDR_W:0]   next_addr;

  logic              vs_fall, vs_rise, href_fall, keep;
  logic [PIX_W-1:0]  pix_next;

  // Register the camera bus once; every decision below uses these copies.
  always_ff @(posedge pclk) begin
    if (rst) begin
      pixd_r  <= '0;
      vsync_r <= 1'b0;
      vsync_q <= 1'b0;
      href_r  <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      pixd_r  <= cam.pixd;
      vsync_r <= cam.vsync;
      vsync_q <= vsync_r;
      href_r  <= cam.href;
      href_q  <= href_r;
    end
  end

  // Edge detects on the registered sync signals and the decimation keep test.
  always_comb begin
    vs_fall   = vsync_q & ~vsync_r;
    vs_rise   = ~vsync_q & vsync_r;
    href_fall = href_q & ~href_r;
    keep      = (col_mod == '0) && (line_mod == '0);
  end

  // Only one earlier beat is ever needed, so the pixel word is built from a
  // single-beat history plus the current beat instead of a full shift register.
  if (BYTES_PER_PIX == 1) begin : g_one_beat
    assign pix_next = pixd_r;
  end else begin : g_two_beat
    assign pix_next = {hist, pixd_r};
  end

  assign busy = (state == S_WAIT_VS) || (state == S_CAPTURE);

  // Frame sequencing, beat packing, decimation and BRAM write generation.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= S_IDLE;
      cam.WE     <= 1'b0;
      cam.WDATA  <= '0;
      cam.WADDR  <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      line_cnt   <= '0;
      next_addr  <= '0;
      phase      <= '0;
      hist       <= '0;
      col_mod    <= '0;
      line_mod   <= '0;
    end else begin
      cam.WE     <= 1'b0;
      frame_done <= 1'b0;

      // WADDR shows the write address with WE, then advances; it holds at the
      // last address once the buffer is full so it never wraps.
      if (cam.WE && (next_addr != DEPTH))
        cam.WADDR <= next_addr[ADDR_W-1:0];

      case (state)
        S_IDLE: begin
          if (arm) begin
            state    <= S_WAIT_VS;
            overflow <= 1'b0;
          end else if (continuous) begin
            state <= S_WAIT_VS;
          end
        end

        S_WAIT_VS: begin
          if (vs_fall) begin
            state     <= S_CAPTURE;
            next_addr <= '0;
            cam.WADDR <= '0;
            line_cnt  <= '0;
            phase     <= '0;
            col_mod   <= '0;
            line_mod  <= '0;
          end
        end

        default: begin
          if (vs_rise) begin
            frame_done <= 1'b1;
            state      <= continuous ? S_WAIT_VS : S_IDLE;
          end else begin
            if (href_fall) begin
              phase    <= '0;
              col_mod  <= '0;
              line_mod <= (line_mod == V_LAST) ? '0 : line_mod + 3'd1;
              if (line_cnt != 10'd1023)
                line_cnt <= line_cnt + 10'd1;
            end
            if (href_r) begin
              hist <= pixd_r;
              if (phase == PH_LAST) begin
                phase   <= '0;
                col_mod <= (col_mod == H_LAST) ? '0 : col_mod + 3'd1;
                if (keep) begin
                  if (state == S_CAPTURE) begin
                    cam.WE    <= 1'b1;
                    cam.WDATA <= pix_next;
                    cam.WADDR <= next_addr[ADDR_W-1:0];
                    next_addr <= next_addr + 1'b1;
                    if (next_addr == LAST_ADDR)
                      state <= S_FULL;
                  end else begin
                    overflow <= 1'b1;
                  end
                end
              end else begin
                phase <= phase + 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_packer.sv
// Bench for cam_capture_packer: two instances (no decimation with an 8-word
// buffer, and 2x2 decimation with a 32-word buffer) share one camera stream.
// Expected writes come from a frame-level reference model over the recorded beats.
`timescale 1ns/1ps
module tb_cam_capture_packer;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic [31:0] cyc;
  } wr_t;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       continuous = 1'b0;
  logic       busy_a, busy_b, fd_a, fd_b, ovf_a, ovf_b;
  logic [9:0] lc_a, lc_b;

  cam_capture_packer_if #(.DATA_W(4), .BYTES_PER_PIX(2), .ADDR_W(3)) cam_a ();
  cam_capture_packer_if #(.DATA_W(4), .BYTES_PER_PIX(2), .ADDR_W(5)) cam_b ();

  cam_capture_packer #(.DATA_W(4), .BYTES_PER_PIX(2), .ADDR_W(3), .H_DECIM(1), .V_DECIM(1)) u_a (
    .pclk(pclk), .rst(rst), .cam(cam_a), .arm(arm), .continuous(continuous),
    .busy(busy_a), .frame_done(fd_a), .overflow(ovf_a), .line_cnt(lc_a)
  );

  cam_capture_packer #(.DATA_W(4), .BYTES_PER_PIX(2), .ADDR_W(5), .H_DECIM(2), .V_DECIM(2)) u_b (
    .pclk(pclk), .rst(rst), .cam(cam_b), .arm(arm), .continuous(continuous),
    .busy(busy_b), .frame_done(fd_b), .overflow(ovf_b), .line_cnt(lc_b)
  );

  always #5 pclk = ~pclk;

  // model configuration per instance: index 0 = u_a, 1 = u_b
  int m_bpp[2]   = '{2, 2};
  int m_h[2]     = '{1, 2};
  int m_v[2]     = '{1, 2};
  int m_depth[2] = '{8, 32};

  // model state
  bit ovf_m[2]   = '{0, 0};
  int fd_m[2]    = '{0, 0};
  int lc_m[2]    = '{0, 0};
  int waddr_m[2] = '{0, 0};

  wr_t got_a[$], got_b[$], exp_a[$], exp_b[$];
  int  fd_cnt_a = 0, fd_cnt_b = 0;
  int  cyc = 0;

  int         fl_len[$];
  logic [3:0] fb_data[$];
  int         fb_cyc[$];
  logic [3:0] preset[$];

  int checks = 0, passed = 0, fails = 0;

  // Write and frame_done monitor, sampled 1 ns after the rising edge.
  always @(posedge pclk) begin
    cyc = cyc + 1;
    #1;
    if (cam_a.WE === 1'b1) got_a.push_back({16'(cam_a.WADDR), 16'(cam_a.WDATA), 32'(cyc)});
    if (cam_b.WE === 1'b1) got_b.push_back({16'(cam_b.WADDR), 16'(cam_b.WDATA), 32'(cyc)});
    if (fd_a === 1'b1) fd_cnt_a = fd_cnt_a + 1;
    if (fd_b === 1'b1) fd_cnt_b = fd_cnt_b + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic vs, input logic hr, input logic [3:0] d,
                       input logic a, input logic r);
    @(negedge pclk);
    cam_a.vsync = vs; cam_a.href = hr; cam_a.pixd = d;
    cam_b.vsync = vs; cam_b.href = hr; cam_b.pixd = d;
    arm = a;
    rst = r;
  endtask

  // One frame: vsync high, fall, lines from fl_len with gaps, vsync rise.
  task automatic send_frame(input int arm_at, input int rst_at);
    int idx;
    logic [3:0] d;
    idx = 0;
    fb_data.delete();
    fb_cyc.delete();
    repeat (2) drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int l = 0; l < fl_len.size(); l++) begin
      for (int b = 0; b < fl_len[l]; b++) begin
        if (preset.size() > 0) d = preset.pop_front();
        else d = 4'($urandom_range(0, 15));
        drive(1'b0, 1'b1, d, idx == arm_at, idx == rst_at);
        fb_data.push_back(d);
        fb_cyc.push_back(cyc);
        idx++;
      end
      repeat (3) drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    end
    repeat (6) drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  // Frame-level reference: pixel c of line l is kept when c%H==0 and l%V==0;
  // the k-th kept pixel goes to address k while k < depth, else it overflows.
  task automatic model_frame(input int w, input int nlines);
    int p, k, npix, data, bpp, last;
    wr_t e;
    p = 0;
    k = 0;
    bpp = m_bpp[w];
    for (int l = 0; l < fl_len.size(); l++) begin
      if (l < nlines) begin
        npix = fl_len[l] / bpp;
        for (int c = 0; c < npix; c++) begin
          if ((c % m_h[w]) == 0 && (l % m_v[w]) == 0) begin
            data = 0;
            for (int j = 0; j < bpp; j++) data = data * 16 + int'(fb_data[p + c * bpp + j]);
            last = fb_cyc[p + c * bpp + bpp - 1];
            if (k < m_depth[w]) begin
              e = {16'(k), 16'(data), 32'(last + 2)};
              if (w == 0) exp_a.push_back(e); else exp_b.push_back(e);
            end else begin
              ovf_m[w] = 1'b1;
            end
            k++;
          end
        end
      end
      p += fl_len[l];
    end
    if (nlines == fl_len.size()) begin
      lc_m[w]    = nlines;
      waddr_m[w] = (k >= m_depth[w]) ? m_depth[w] - 1 : k;
      fd_m[w]    = fd_m[w] + 1;
    end
  endtask

  task automatic check_frame(input string tag, input logic exp_busy);
    chk({tag, " nwr_a"}, 64'(got_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      chk({tag, " wr_a"}, 64'(got_a[i]), 64'(exp_a[i]));
    chk({tag, " nwr_b"}, 64'(got_b.size()), 64'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      chk({tag, " wr_b"}, 64'(got_b[i]), 64'(exp_b[i]));
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
    chk({tag, " fd_a"},    64'(fd_cnt_a),    64'(fd_m[0]));
    chk({tag, " fd_b"},    64'(fd_cnt_b),    64'(fd_m[1]));
    chk({tag, " ovf_a"},   64'(ovf_a),       64'(ovf_m[0]));
    chk({tag, " ovf_b"},   64'(ovf_b),       64'(ovf_m[1]));
    chk({tag, " waddr_a"}, 64'(cam_a.WADDR), 64'(waddr_m[0]));
    chk({tag, " waddr_b"}, 64'(cam_b.WADDR), 64'(waddr_m[1]));
    chk({tag, " lc_a"},    64'(lc_a),        64'(lc_m[0]));
    chk({tag, " lc_b"},    64'(lc_b),        64'(lc_m[1]));
    chk({tag, " busy_a"},  64'(busy_a),      64'(exp_busy));
    chk({tag, " busy_b"},  64'(busy_b),      64'(exp_busy));
    chk({tag, " we_idle"}, 64'({cam_a.WE, cam_b.WE}), 64'(0));
  endtask

  // Arm from IDLE: must go busy and clear the sticky overflow.
  task automatic pulse_arm(input string tag);
    drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    ovf_m[0] = 1'b0;
    ovf_m[1] = 1'b0;
    chk({tag, " arm_busy"}, 64'({busy_a, busy_b}), 64'(2'b11));
    chk({tag, " arm_ovf"},  64'({ovf_a, ovf_b}),   64'(2'b00));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " we"},    64'({cam_a.WE, cam_b.WE}),       64'(0));
    chk({tag, " wdata"}, 64'({cam_a.WDATA, cam_b.WDATA}), 64'(0));
    chk({tag, " waddr"}, 64'({cam_a.WADDR, cam_b.WADDR}), 64'(0));
    chk({tag, " busy"},  64'({busy_a, busy_b}),           64'(0));
    chk({tag, " fd"},    64'({fd_a, fd_b}),               64'(0));
    chk({tag, " ovf"},   64'({ovf_a, ovf_b}),             64'(0));
    chk({tag, " lc"},    64'({lc_a, lc_b}),               64'(0));
  endtask

  initial begin
    int nl;
    cam_a.vsync = 1'b1; cam_a.href = 1'b0; cam_a.pixd = 4'h0;
    cam_b.vsync = 1'b1; cam_b.href = 1'b0; cam_b.pixd = 4'h0;

    // reset state
    repeat (3) @(negedge pclk);
    check_zero("reset");
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

    // single line A,B,C,D -> 0xAB @0, 0xCD @1 on the undecimated instance
    pulse_arm("t1");
    preset.push_back(4'hA); preset.push_back(4'hB);
    preset.push_back(4'hC); preset.push_back(4'hD);
    fl_len = '{4};
    send_frame(-1, -1);
    model_frame(0, 1);
    model_frame(1, 1);
    if (got_a.size() == 2) begin
      chk("t1 data0", 64'(got_a[0].data), 64'h00AB);
      chk("t1 data1", 64'(got_a[1].data), 64'h00CD);
    end else begin
      chk("t1 nwr", 64'(got_a.size()), 64'(2));
    end
    check_frame("t1", 1'b0);

    // 4 lines x 8 pixels; arm pulsed mid-frame while busy/full must be ignored
    pulse_arm("t2");
    fl_len = '{16, 16, 16, 16};
    send_frame(40, -1);
    model_frame(0, 4);
    model_frame(1, 4);
    chk("t2 waddr_b8", 64'(cam_b.WADDR), 64'(8));
    chk("t2 lc_b4",    64'(lc_b),        64'(4));
    chk("t2 ovf_a",    64'(ovf_a),       64'(1));
    check_frame("t2", 1'b0);

    // one line of 12 pixels into the 8-word buffer
    pulse_arm("t3");
    fl_len = '{24};
    send_frame(-1, -1);
    model_frame(0, 1);
    model_frame(1, 1);
    chk("t3 waddr_a7", 64'(cam_a.WADDR), 64'(7));
    check_frame("t3", 1'b0);

    // arm mid-frame: this frame is skipped, the next one starts at address 0
    fl_len = '{10, 10};
    send_frame(3, -1);
    ovf_m[0] = 1'b0;
    ovf_m[1] = 1'b0;
    check_frame("t4a", 1'b1);
    fl_len = '{10};
    send_frame(-1, -1);
    model_frame(0, 1);
    model_frame(1, 1);
    if (got_a.size() > 0) chk("t4 first_addr", 64'(got_a[0].addr), 64'(0));
    check_frame("t4b", 1'b0);

    // continuous capture: three 5-pixel frames, a 3-beat line, then random frames
    continuous = 1'b1;
    for (int f = 0; f < 3; f++) begin
      fl_len = '{10};
      send_frame(-1, -1);
      model_frame(0, 1);
      model_frame(1, 1);
      check_frame("t5 five", 1'b1);
    end
    fl_len = '{3};
    send_frame(-1, -1);
    model_frame(0, 1);
    model_frame(1, 1);
    check_frame("t5 odd", 1'b1);
    for (int f = 0; f < 6; f++) begin
      fl_len.delete();
      nl = int'($urandom_range(1, 4));
      for (int l = 0; l < nl; l++) fl_len.push_back(int'($urandom_range(1, 20)));
      if (f == 5) continuous = 1'b0;
      send_frame(-1, -1);
      model_frame(0, nl);
      model_frame(1, nl);
      check_frame("t5 rand", continuous);
    end

    // reset in the middle of line 1: only line 0 is written, then everything is 0
    pulse_arm("t6");
    fl_len = '{6, 10, 8};
    send_frame(-1, 7);
    model_frame(0, 1);
    model_frame(1, 1);
    ovf_m[0] = 1'b0; ovf_m[1] = 1'b0;
    lc_m[0] = 0; lc_m[1] = 0;
    waddr_m[0] = 0; waddr_m[1] = 0;
    check_frame("t6 rst", 1'b0);
    check_zero("t6 after_rst");
    fl_len = '{8};
    send_frame(-1, -1);
    check_frame("t6 noarm", 1'b0);
    pulse_arm("t6b");
    fl_len = '{8, 8};
    send_frame(-1, -1);
    model_frame(0, 2);
    model_frame(1, 2);
    check_frame("t6 rearm", 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
